// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes the PS/2 set-2 scancode byte stream into a live
// 512-entry key_down map and a one-cycle key_valid event strobe.
// Handles the E0 (extended) and F0 (break) prefixes, skips the 8-byte E1 Pause
// sequence and drops a prefix that has been pending for too long.
//
// Handshake: byte_valid is a one-cycle strobe with no ready. Every strobed
// byte is consumed in the cycle it arrives. Strobes may be back-to-back.
// An event produced by a byte in cycle N appears in cycle N+1 as key_valid=1,
// together with last_change/is_break and the updated key_down.
//
// dbg_state encoding: 0=IDLE 1=EXT 2=BRK 3=EXT_BRK 4=SKIP
module ps2_key_tracker #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int TO_W        = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         is_break,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t          r_state;
  logic [2:0]      r_skip;
  logic [TO_W-1:0] r_to_cnt;

  // Keyboard housekeeping bytes (BAT result, ACK, resend, echo, errors)
  logic w_ignored;
  // Fake-shift codes that follow E0 on some keys and must not register
  logic w_fake_shift;

  assign w_ignored    = (byte_data == 8'hAA) || (byte_data == 8'hFA) ||
                        (byte_data == 8'hFE) || (byte_data == 8'hEE) ||
                        (byte_data == 8'h00) || (byte_data == 8'hFF);
  assign w_fake_shift = (byte_data == 8'h12) || (byte_data == 8'h59);
  assign dbg_state    = r_state;

  // Prefix FSM, timeout counter, Pause skip counter and key map, all registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_skip      <= 3'd0;
      r_to_cnt    <= '0;
      key_down    <= '0;
      last_change <= 9'd0;
      key_valid   <= 1'b0;
      is_break    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (byte_valid) begin
        // A byte always wins over a coincident timeout expiry
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (byte_data == 8'hE0) begin
              r_state <= S_EXT;
            end else if (byte_data == 8'hF0) begin
              r_state <= S_BRK;
            end else if (byte_data == 8'hE1) begin
              r_state <= S_SKIP;
              r_skip  <= 3'd7;
            end else if (!w_ignored) begin
              key_down[{1'b0, byte_data}] <= 1'b1;
              last_change                 <= {1'b0, byte_data};
              is_break                    <= 1'b0;
              key_valid                   <= 1'b1;
            end
          end
          S_EXT: begin
            if (byte_data == 8'hF0) begin
              r_state <= S_EXT_BRK;
            end else if (byte_data == 8'hE0) begin
              r_state <= S_EXT;
            end else if (w_fake_shift) begin
              r_state <= S_IDLE;
            end else begin
              key_down[{1'b1, byte_data}] <= 1'b1;
              last_change                 <= {1'b1, byte_data};
              is_break                    <= 1'b0;
              key_valid                   <= 1'b1;
              r_state                     <= S_IDLE;
            end
          end
          S_BRK: begin
            key_down[{1'b0, byte_data}] <= 1'b0;
            last_change                 <= {1'b0, byte_data};
            is_break                    <= 1'b1;
            key_valid                   <= 1'b1;
            r_state                     <= S_IDLE;
          end
          S_EXT_BRK: begin
            if (!w_fake_shift) begin
              key_down[{1'b1, byte_data}] <= 1'b0;
              last_change                 <= {1'b1, byte_data};
              is_break                    <= 1'b1;
              key_valid                   <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          S_SKIP: begin
            if (r_skip <= 3'd1) begin
              r_skip  <= 3'd0;
              r_state <= S_IDLE;
            end else begin
              r_skip <= r_skip - 3'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        // The TIMEOUT_CYC-th consecutive idle cycle drops the pending prefix
        if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          r_state  <= S_IDLE;
          r_skip   <= 3'd0;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

endmodule
